// File: rtl/alu_muldiv_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
// A transfer happens on any rising edge where valid and ready are both high.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] req_a_data_i;
  logic [XLEN-1:0] req_b_data_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_data_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_data_i, req_b_data_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_data_i, req_b_data_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o
  );
endinterface

// File: rtl/alu_muldiv.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit (IDLE -> CALC -> DONE).
// Define ALU_MULDIV_EARLY_OUT_EN to finish div-by-zero, signed overflow and zero multiplies in one cycle.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  alu_muldiv_if.slave  bus,
  output logic         busy_o,
  output logic [1:0]   state_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            accept, a_sgn, b_sgn, b_zero, neg_in;
  logic [2:0]      op_in;
  logic [XLEN-1:0] a_in, b_in, a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_diff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0] div_sel, final_res;

  assign op_in  = bus.req_op_i;
  assign a_in   = bus.req_a_data_i;
  assign b_in   = bus.req_b_data_i;
  assign accept = bus.req_valid_i && (state_q == S_IDLE) && !flush_i;

  // Operand conditioning: magnitudes into the unsigned core, result sign recorded.
  always_comb begin
    a_sgn  = a_in[XLEN-1] && (op_in inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_sgn  = b_in[XLEN-1] && (op_in inside {3'b001, 3'b100, 3'b110});
    a_mag  = a_sgn ? -a_in : a_in;
    b_mag  = b_sgn ? -b_in : b_in;
    b_zero = (b_in == '0);
    case (op_in)
      3'b001:  neg_in = a_sgn ^ b_sgn;
      3'b010:  neg_in = a_sgn;
      3'b100:  neg_in = (a_sgn ^ b_sgn) && !b_zero;  // x/0 must stay all ones
      3'b110:  neg_in = a_sgn;
      default: neg_in = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EARLY_OUT_EN
  logic            ovf_in, mzero_in, dzero_in, early_hit;
  logic [XLEN-1:0] early_res;
  always_comb begin
    ovf_in    = (op_in == 3'b100 || op_in == 3'b110) &&
                (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (&b_in);
    mzero_in  = !op_in[2] && (a_in == '0 || b_zero);
    dzero_in  = op_in[2] && b_zero;
    early_hit = ovf_in || mzero_in || dzero_in;
    if (mzero_in)      early_res = '0;
    else if (dzero_in) early_res = op_in[1] ? a_in : '1;
    else               early_res = op_in[1] ? '0 : a_in;
  end
`endif

  // One iteration: multiply shifts the accumulator right adding the multiplicand;
  // division shifts left and subtracts the divisor when it fits (restoring).
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift[XLEN-1:0] - m_q;
    if (!op_q[2])
      step = {mul_sum, acc_q[XLEN-1:1]};
    else if (div_shift >= {1'b0, m_q})
      step = {div_diff, acc_q[XLEN-2:0], 1'b1};
    else
      step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod    = neg_q ? -step : step;
    div_sel = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    if (op_q[2])              final_res = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == '0) final_res = prod[XLEN-1:0];
    else                      final_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d    = op_in;
        neg_d   = neg_in;
        m_d     = op_in[2] ? b_mag : a_mag;
        acc_d   = {{XLEN{1'b0}}, (op_in[2] ? a_mag : b_mag)};
        cnt_d   = '0;
        state_d = S_CALC;
`ifdef ALU_MULDIV_EARLY_OUT_EN
        if (early_hit) begin
          state_d = S_DONE;
          res_d   = early_res;
        end
`endif
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_DONE;
          res_d   = final_res;
        end
      end
      S_DONE:  if (bus.resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus.req_ready_o  = (state_q == S_IDLE);
    bus.resp_valid_o = (state_q == S_DONE);
    bus.resp_data_o  = res_q;
    busy_o           = (state_q != S_IDLE);
    state_o          = state_q;
  end
endmodule
